// File: rtl/ad7671_conv_sequencer.sv
// Conversion/readback engine for the four AD7671 ADCs: common convert start, BUSY wait,
// sequential CS_n/RD_n reads of U1..U4, results queued in a show-ahead FIFO for the host.
`timescale 1ns/1ps
module ad7671_conv_sequencer #(
   parameter int CNV_LOW_CYC  = 2,
   parameter int RD_LOW_CYC   = 3,
   parameter int BUSY_MIN_CYC = 4,
   parameter int BUSY_TMO_CYC = 256,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               cont_i,
   output logic               cnvst_n_o,
   input  logic [3:0]         busy_i,
   output logic [3:0]         cs_n_o,
   output logic               rd_n_o,
   input  logic [15:0]        db_i,
   input  logic               host_rd_i,
   output logic [15:0]        host_data_o,
   output logic               fifo_empty_o,
   output logic               fifo_full_o,
   output logic [FIFO_AW:0]   fifo_cnt_o,
   output logic               seq_busy_o,
   output logic               ovf_o,
   output logic               tmo_o,
   input  logic               clr_err_i
);

   localparam int CW = $clog2(BUSY_TMO_CYC + 1);
   localparam logic [CW-1:0] CNV_LAST = CW'(CNV_LOW_CYC);
   localparam logic [CW-1:0] RD_LAST  = CW'(RD_LOW_CYC);
   localparam logic [CW-1:0] BUSY_MIN = CW'(BUSY_MIN_CYC);
   localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TMO_CYC);
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(2 ** FIFO_AW);

   typedef enum logic [2:0] {S_IDLE, S_CNV, S_WAIT, S_RD, S_GAP} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [1:0]         k_q;
   logic               cnvst_n_q;
   logic [3:0]         cs_n_q;
   logic               rd_n_q;
   logic               tmo_q;
   logic               ovf_q;
   logic [3:0]         busyMeta_q;
   logic [3:0]         busySync_q;
   logic [15:0]        mem_q [2**FIFO_AW];
   logic [FIFO_AW-1:0] wptr_q;
   logic [FIFO_AW-1:0] rptr_q;
   logic [FIFO_AW:0]   fcnt_q;
   logic [FIFO_AW:0]   fcnt_d;
   logic               push;
   logic               pushOk;
   logic               popOk;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busyMeta_q <= 4'h0;
         busySync_q <= 4'h0;
      end else begin
         busyMeta_q <= busy_i;
         busySync_q <= busyMeta_q;
      end
   end

   // cnt_q keeps counting from the CNVST_n falling edge through CNV and WAIT,
   // and is reused as the low-cycle counter inside each read.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         k_q       <= 2'd0;
         cnvst_n_q <= 1'b1;
         cs_n_q    <= 4'hF;
         rd_n_q    <= 1'b1;
         tmo_q     <= 1'b0;
      end else begin
         tmo_q <= tmo_q & ~clr_err_i;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q   <= S_CNV;
                  cnvst_n_q <= 1'b0;
                  cnt_q     <= CW'(1);
               end
            end
            S_CNV: begin
               if (cnt_q == CNV_LAST) begin
                  state_q   <= S_WAIT;
                  cnvst_n_q <= 1'b1;
               end
               cnt_q <= cnt_q + CW'(1);
            end
            S_WAIT: begin
               if ((cnt_q >= BUSY_MIN) && (busySync_q == 4'h0)) begin
                  state_q <= S_RD;
                  k_q     <= 2'd0;
                  cs_n_q  <= 4'b1110;
                  rd_n_q  <= 1'b0;
                  cnt_q   <= CW'(1);
               end else if (cnt_q == TMO_LAST) begin
                  state_q <= S_IDLE;
                  tmo_q   <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RD: begin
               if (cnt_q == RD_LAST) begin
                  state_q <= S_GAP;
                  cs_n_q  <= 4'hF;
                  rd_n_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_GAP: begin
               if (k_q == 2'd3) begin
                  if (cont_i) begin
                     state_q   <= S_CNV;
                     cnvst_n_q <= 1'b0;
                     cnt_q     <= CW'(1);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  state_q <= S_RD;
                  k_q     <= k_q + 2'd1;
                  cs_n_q  <= ~(4'b0001 << (k_q + 2'd1));
                  rd_n_q  <= 1'b0;
                  cnt_q   <= CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // DB is captured straight into the FIFO at the edge that ends the last low read cycle.
   assign push   = (state_q == S_RD) && (cnt_q == RD_LAST);
   assign popOk  = host_rd_i && (fcnt_q != '0);
   assign pushOk = push && ((fcnt_q != FULL_CNT) || popOk);

   always_comb begin
      fcnt_d = fcnt_q;
      if (pushOk && !popOk) begin
         fcnt_d = fcnt_q + (FIFO_AW + 1)'(1);
      end else if (!pushOk && popOk) begin
         fcnt_d = fcnt_q - (FIFO_AW + 1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (pushOk) wptr_q <= wptr_q + FIFO_AW'(1);
         if (popOk)  rptr_q <= rptr_q + FIFO_AW'(1);
         fcnt_q <= fcnt_d;
         ovf_q  <= (push && !pushOk) | (ovf_q & ~clr_err_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (pushOk) mem_q[wptr_q] <= db_i;
   end

   assign host_data_o  = (fcnt_q == '0) ? 16'h0000 : mem_q[rptr_q];
   assign fifo_empty_o = (fcnt_q == '0);
   assign fifo_full_o  = (fcnt_q == FULL_CNT);
   assign fifo_cnt_o   = fcnt_q;
   assign seq_busy_o   = (state_q != S_IDLE);
   assign ovf_o        = ovf_q;
   assign tmo_o        = tmo_q;
   assign cnvst_n_o    = cnvst_n_q;
   assign cs_n_o       = cs_n_q;
   assign rd_n_o       = rd_n_q;

endmodule

// File: tb/tb_ad7671_conv_sequencer.sv
// Scoreboard bench for ad7671_conv_sequencer: an ADC bus model answers reads, expected
// words and read selects are queued by the stimulus and checked by independent monitors.
`timescale 1ns/1ps
module tb_ad7671_conv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic        cnvst_n;
   logic [3:0]  busy = 4'h0;
   logic [3:0]  cs_n;
   logic        rd_n;
   logic [15:0] db;
   logic        host_rd = 1'b0;
   logic [15:0] host_data;
   logic        fifo_empty;
   logic        fifo_full;
   logic [4:0]  fifo_cnt;
   logic        seq_busy;
   logic        ovf;
   logic        tmo;
   logic        clr_err = 1'b0;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] expq[$];
   int          csq[$];
   logic [15:0] vals [4];
   logic [15:0] setsDone = 16'd0;
   int          cnvFalls = 0;
   logic        prevCnv = 1'b1;
   logic        inRead = 1'b0;
   int          lowLen = 0;
   int          curK = 0;

   ad7671_conv_sequencer dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .start_i      (start),
      .cont_i       (cont),
      .cnvst_n_o    (cnvst_n),
      .busy_i       (busy),
      .cs_n_o       (cs_n),
      .rd_n_o       (rd_n),
      .db_i         (db),
      .host_rd_i    (host_rd),
      .host_data_o  (host_data),
      .fifo_empty_o (fifo_empty),
      .fifo_full_o  (fifo_full),
      .fifo_cnt_o   (fifo_cnt),
      .seq_busy_o   (seq_busy),
      .ovf_o        (ovf),
      .tmo_o        (tmo),
      .clr_err_i    (clr_err)
   );

   always #5 clk = ~clk;

   // ADC bus model: the selected converter drives its value offset by the completed-set count
   always_comb begin
      db = 16'hDEAD;
      for (int k = 0; k < 4; k++) begin
         if (!cs_n[k]) db = vals[k] + setsDone;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // FIFO monitor: every accepted host pop is compared with the scoreboard head
   always @(negedge clk) begin
      if (rst_n && host_rd && !fifo_empty) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_word: got %0h expected none", host_data);
         end else begin
            checkOutput("fifo_word", {16'h0, host_data}, {16'h0, expq.pop_front()});
         end
      end
   end

   // Bus monitor: read select order, read strobe length and convert-start count
   always @(negedge clk) begin
      logic [3:0] expCs;
      if (!rst_n) begin
         inRead = 1'b0;
         lowLen = 0;
         prevCnv = 1'b1;
      end else begin
         if (!cnvst_n && prevCnv) cnvFalls++;
         prevCnv = cnvst_n;
         if (!rd_n && !inRead) begin
            inRead = 1'b1;
            lowLen = 1;
            if (csq.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_read: got cs_n %0h expected no read", cs_n);
               curK = -1;
            end else begin
               curK = csq.pop_front();
               expCs = 4'hF ^ (4'b0001 << curK);
               checkOutput("cs_select", {28'h0, cs_n}, {28'h0, expCs});
            end
         end else if (!rd_n) begin
            lowLen++;
         end else if (inRead) begin
            inRead = 1'b0;
            checkOutput("rd_low_len", lowLen, 3);
            if (curK == 3) setsDone++;
         end
      end
   end

   task automatic applyStimulus();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic clrErr();
      @(posedge clk); #1 clr_err = 1'b1;
      @(posedge clk); #1 clr_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic popWords(input int n);
      @(posedge clk); #1 host_rd = 1'b1;
      repeat (n) @(posedge clk);
      #1 host_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      @(negedge clk);
      while (seq_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_reached", {31'h0, seq_busy}, 32'h0);
   endtask

   task automatic expectSet(input int nSets);
      for (int s = 0; s < nSets; s++) begin
         for (int k = 0; k < 4; k++) begin
            expq.push_back(vals[k] + setsDone + 16'(s));
            csq.push_back(k);
         end
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int lowCnt;
      int cnvBefore;
      vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      repeat (3) @(negedge clk);
      checkOutput("rst_cnvst_n", {31'h0, cnvst_n}, 32'h1);
      checkOutput("rst_cs_n", {28'h0, cs_n}, 32'hF);
      checkOutput("rst_rd_n", {31'h0, rd_n}, 32'h1);
      checkOutput("rst_fifo_cnt", {27'h0, fifo_cnt}, 32'h0);
      checkOutput("rst_fifo_empty", {31'h0, fifo_empty}, 32'h1);
      checkOutput("rst_host_data", {16'h0, host_data}, 32'h0);
      checkOutput("rst_flags", {30'h0, ovf, tmo}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] basic set");
      expectSet(1);
      busy = 4'hF;
      applyStimulus();
      lowCnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!cnvst_n) lowCnt++;
      end
      busy = 4'h0;
      checkOutput("cnvst_low_cycles", lowCnt, 2);
      waitIdle(200);
      checkOutput("set_fifo_cnt", {27'h0, fifo_cnt}, 32'd4);
      popWords(4);
      checkOutput("drained_empty", {31'h0, fifo_empty}, 32'h1);

      $display("[TB] busy timeout");
      busy = 4'hF;
      applyStimulus();
      n = 0;
      while (!tmo && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("tmo_set", {31'h0, tmo}, 32'h1);
      checkOutput("tmo_latency_window", {31'h0, (n >= 256 && n <= 258)}, 32'h1);
      checkOutput("tmo_cs_n", {28'h0, cs_n}, 32'hF);
      checkOutput("tmo_fifo_cnt", {27'h0, fifo_cnt}, 32'h0);
      checkOutput("tmo_idle", {31'h0, seq_busy}, 32'h0);
      busy = 4'h0;
      clrErr();
      checkOutput("tmo_cleared", {31'h0, tmo}, 32'h0);

      $display("[TB] continuous overflow");
      vals = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
      expectSet(4);
      for (int k = 0; k < 4; k++) csq.push_back(k);
      n = setsDone;
      cont = 1'b1;
      applyStimulus();
      lowCnt = 0;
      while (setsDone != 16'(n + 4) && lowCnt < 2000) begin
         @(negedge clk);
         lowCnt++;
      end
      checkOutput("four_sets_full", {31'h0, fifo_full}, 32'h1);
      checkOutput("four_sets_no_ovf", {31'h0, ovf}, 32'h0);
      lowCnt = 0;
      while (cnvst_n && lowCnt < 50) begin
         @(negedge clk);
         lowCnt++;
      end
      cont = 1'b0;
      waitIdle(200);
      checkOutput("fifth_set_ovf", {31'h0, ovf}, 32'h1);
      checkOutput("fifth_set_cnt", {27'h0, fifo_cnt}, 32'd16);
      clrErr();
      checkOutput("ovf_cleared", {31'h0, ovf}, 32'h0);

      $display("[TB] push and pop while full");
      expectSet(1);
      applyStimulus();
      for (int r = 0; r < 4; r++) begin
         n = 0;
         @(negedge clk);
         while (rd_n && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput("read_started", {31'h0, rd_n}, 32'h0);
         @(posedge clk); #1;
         @(posedge clk); #1 host_rd = 1'b1;
         @(posedge clk); #1 host_rd = 1'b0;
      end
      waitIdle(200);
      checkOutput("full_pushpop_cnt", {27'h0, fifo_cnt}, 32'd16);
      checkOutput("full_pushpop_ovf", {31'h0, ovf}, 32'h0);
      popWords(16);
      checkOutput("full_drained", {27'h0, fifo_cnt}, 32'h0);

      $display("[TB] reset during read");
      vals = '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
      expectSet(1);
      applyStimulus();
      n = 0;
      @(negedge clk);
      while (!(cs_n == 4'b1011 && !rd_n) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rd2_reached", {28'h0, cs_n}, 32'hB);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_cs_n", {28'h0, cs_n}, 32'hF);
      checkOutput("async_rd_n", {31'h0, rd_n}, 32'h1);
      checkOutput("async_fifo_cnt", {27'h0, fifo_cnt}, 32'h0);
      expq.delete();
      csq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expectSet(1);
      applyStimulus();
      waitIdle(200);
      checkOutput("post_reset_cnt", {27'h0, fifo_cnt}, 32'd4);
      popWords(4);

      $display("[TB] empty pops, start in wait, staggered busy");
      popWords(2);
      checkOutput("empty_pop_cnt", {27'h0, fifo_cnt}, 32'h0);
      vals = '{16'h5151, 16'h6262, 16'h7373, 16'h8484};
      expectSet(1);
      cnvBefore = cnvFalls;
      busy = 4'hF;
      applyStimulus();
      repeat (8) @(negedge clk);
      applyStimulus();
      busy = 4'hE;
      repeat (3) @(negedge clk);
      busy = 4'hC;
      repeat (3) @(negedge clk);
      busy = 4'h8;
      repeat (4) @(negedge clk);
      checkOutput("stagger_no_read", {27'h0, rd_n, cs_n}, 32'h1F);
      checkOutput("stagger_waiting", {31'h0, seq_busy}, 32'h1);
      busy = 4'h0;
      waitIdle(200);
      checkOutput("one_cnvst", cnvFalls - cnvBefore, 1);
      checkOutput("stagger_cnt", {27'h0, fifo_cnt}, 32'd4);
      popWords(4);

      checkOutput("words_left", expq.size(), 0);
      checkOutput("reads_left", csq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
